// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and constants for the RV64 instruction fetch buffer.
// Optional FETCH_PERF_EN build adds fetch performance counters.
package inst_fetch_buffer_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_fifo.sv
// fetch_fifo: DEPTH-entry queue of {pc, inst} pairs with flush.
// Head is read straight from storage; count tracks occupancy.
module fetch_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [ILEN-1:0] push_inst,
  input  logic            pop,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_inst,
  output logic [CW-1:0]   count
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  assign head_pc    = mem[rd_ptr].pc;
  assign head_inst  = mem[rd_ptr].inst;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush && push)
      mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// RV64 fetch stage: owns the PC, issues reads, queues words for decode.
// Define FETCH_PERF_EN to add perf_fetched / perf_stall counters.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] id_inst,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stall
`else
  output logic [31:0] id_inst
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_state_e  state_q, state_d;
  logic [63:0]   pc_q;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   inflight;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          head_valid;
  logic [31:0]   head_inst;

  // PCs of granted requests, oldest at aq_rd
  logic [63:0]   aq [DEPTH];
  logic [AW-1:0] aq_wr;
  logic [AW-1:0] aq_rd;

  assign inflight  = {1'b0, out_q} + {1'b0, fifo_count};
  assign imem_addr = pc_q;

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    rsp      = imem_rvalid && (out_q != '0);
    if (rstn && !redirect && state_q == RUN)
      imem_req = inflight < (CW+1)'(DEPTH);
    grant = imem_req && imem_gnt;
    out_d = out_q + CW'(grant) - CW'(rsp);
    push  = rsp && !redirect && state_q == RUN;
    unique case (1'b1)
      redirect:
        state_d = (out_d != '0) ? DRAIN : RUN;
      !redirect && state_q == DRAIN && out_d == '0:
        state_d = RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      aq_wr   <= '0;
      aq_rd   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (redirect)
        pc_q <= redirect_pc & ~64'd3;
      else if (grant)
        pc_q <= pc_q + 64'd4;
      if (grant)
        aq_wr <= aq_wr + 1'b1;
      if (rsp)
        aq_rd <= aq_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant)
      aq[aq_wr] <= pc_q;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (redirect),
    .push      (push),
    .push_pc   (aq[aq_rd]),
    .push_inst (imem_rdata),
    .pop       (id_ready),
    .head_valid(head_valid),
    .head_pc   (id_pc),
    .head_inst (head_inst),
    .count     (fifo_count)
  );

  assign id_valid = head_valid;
  assign id_inst  = head_valid ? head_inst : NOP_INST;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)
        perf_fetched <= perf_fetched + 64'd1;
      if (!head_valid && state_q == RUN)
        perf_stall <= perf_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer (DEPTH=2, RESET_PC=0).
// Streaming, backpressure, redirect drain, redirect flush, mid-run reset.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall;
`endif

  int nvec = 0;
  int nerr = 0;

  inst_fetch_buffer #(
    .RESET_PC(64'h0),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
`ifdef FETCH_PERF_EN
    .id_inst    (id_inst),
    .perf_fetched(perf_fetched),
    .perf_stall (perf_stall)
`else
    .id_inst    (id_inst)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5a5a_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, check #1 later (before posedge)
  task automatic step(input int c, input logic rs, input logic g,
                      input logic r, input logic v,
                      input logic [63:0] va, input logic rd,
                      input logic [63:0] rp, input logic e_req,
                      input logic [63:0] e_addr, input logic e_idv,
                      input logic [63:0] e_pc);
    @(negedge clk);
    rstn        = rs;
    imem_gnt    = g;
    id_ready    = r;
    imem_rvalid = v;
    imem_rdata  = inst_of(va);
    redirect    = rd;
    redirect_pc = rp;
    #1;
    chk($sformatf("c%0d_req", c), 64'(imem_req), 64'(e_req));
    if (e_req)
      chk($sformatf("c%0d_addr", c), imem_addr, e_addr);
    chk($sformatf("c%0d_idv", c), 64'(id_valid), 64'(e_idv));
    if (e_idv) begin
      chk($sformatf("c%0d_pc", c), id_pc, e_pc);
      chk($sformatf("c%0d_inst", c), 64'(id_inst), 64'(inst_of(e_pc)));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_idv", 64'(id_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    //    c  rs g  r  v  va       rd rp        req addr     idv pc
    // streaming with 1-cycle memory
    step(0,  1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h0,    0, 64'h0);
    step(1,  1, 1, 1, 1, 64'h0,  0, 64'h0,    1, 64'h4,    0, 64'h0);
    step(2,  1, 1, 1, 1, 64'h4,  0, 64'h0,    0, 64'h0,    1, 64'h0);
    step(3,  1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h8,    1, 64'h4);
    step(4,  1, 1, 1, 1, 64'h8,  0, 64'h0,    1, 64'hc,    0, 64'h0);
    step(5,  1, 1, 1, 1, 64'hc,  0, 64'h0,    0, 64'h0,    1, 64'h8);
    step(6,  1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h10,   1, 64'hc);
    // decode stalled: FIFO fills, requests stop
    step(7,  1, 1, 0, 1, 64'h10, 0, 64'h0,    1, 64'h14,   0, 64'h0);
    step(8,  1, 1, 0, 1, 64'h14, 0, 64'h0,    0, 64'h0,    1, 64'h10);
    step(9,  1, 1, 0, 0, 64'h0,  0, 64'h0,    0, 64'h0,    1, 64'h10);
    step(10, 1, 1, 0, 0, 64'h0,  0, 64'h0,    0, 64'h0,    1, 64'h10);
    // release: no loss, streaming resumes
    step(11, 1, 1, 1, 0, 64'h0,  0, 64'h0,    0, 64'h0,    1, 64'h10);
    step(12, 1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h18,   1, 64'h14);
    step(13, 1, 1, 1, 1, 64'h18, 0, 64'h0,    1, 64'h1c,   0, 64'h0);
    step(14, 1, 1, 1, 1, 64'h1c, 0, 64'h0,    0, 64'h0,    1, 64'h18);
    // two in flight, then redirect to 0x1002
    step(15, 1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h20,   1, 64'h1c);
    step(16, 1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h24,   0, 64'h0);
    step(17, 1, 1, 1, 0, 64'h0,  1, 64'h1002, 0, 64'h0,    0, 64'h0);
    step(18, 1, 1, 1, 1, 64'h20, 0, 64'h0,    0, 64'h0,    0, 64'h0);
    step(19, 1, 1, 1, 1, 64'h24, 0, 64'h0,    0, 64'h0,    0, 64'h0);
    step(20, 1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h1000, 0, 64'h0);
    // redirect coinciding with rvalid and a pop
    step(21, 1, 0, 1, 1, 64'h1000, 0, 64'h0,  1, 64'h1004, 0, 64'h0);
    step(22, 1, 1, 0, 0, 64'h0,  0, 64'h0,    1, 64'h1004, 1, 64'h1000);
    step(23, 1, 1, 1, 1, 64'h1004, 1, 64'h2000, 0, 64'h0,  1, 64'h1000);
    step(24, 1, 0, 1, 0, 64'h0,  0, 64'h0,    1, 64'h2000, 0, 64'h0);
    // reset with two in flight, stray responses afterwards
    step(25, 1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h2000, 0, 64'h0);
    step(26, 1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h2004, 0, 64'h0);
    step(27, 0, 1, 1, 0, 64'h0,  0, 64'h0,    0, 64'h0,    0, 64'h0);
    step(28, 1, 0, 1, 1, 64'h2000, 0, 64'h0,  1, 64'h0,    0, 64'h0);
    step(29, 1, 0, 1, 1, 64'h2004, 0, 64'h0,  1, 64'h0,    0, 64'h0);
    step(30, 1, 1, 1, 0, 64'h0,  0, 64'h0,    1, 64'h0,    0, 64'h0);
    step(31, 1, 0, 1, 1, 64'h0,  0, 64'h0,    1, 64'h4,    0, 64'h0);
    step(32, 1, 0, 1, 0, 64'h0,  0, 64'h0,    1, 64'h4,    1, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
